// File: rtl/uart_txrx_core.sv
// 8N1 UART transmitter and receiver sharing one clock domain.
// TX is paced by a free-running baud tick; RX oversamples with its own bit counter.
module uart_txrx_core #(
   parameter int unsigned CLK_FREQ     = 50_000_000,
   parameter int unsigned BAUD         = 115_200,
   parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD
) (
   input  logic       clk_50M,
   input  logic       rst_n,
   input  logic       write_en,
   input  logic [7:0] write_data,
   output logic       uart_txd,
   output logic       busy,
   output logic       baud_tick,
   input  logic       data_serial,
   output logic       out_RX_D,
   output logic [7:0] out_RX_byte
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntMax  = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxCleanup} rx_state_e;

   // ---------------- baud generator ----------------
   logic [CntW-1:0] baud_cnt_q;

   assign baud_tick = (baud_cnt_q == CntMax);

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) baud_cnt_q <= '0;
      else        baud_cnt_q <= baud_tick ? '0 : baud_cnt_q + CntW'(1);
   end

   // ---------------- transmitter ----------------
   tx_state_e  tx_state_q, tx_state_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic [2:0] tx_idx_q, tx_idx_d;
   logic       txd_q, txd_d;
   logic       busy_q, busy_d;

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) tx_state_q <= TxIdle;
      else        tx_state_q <= tx_state_d;
   end

   always_comb begin
      tx_state_d = tx_state_q;
      if (baud_tick) begin
         unique case (tx_state_q)
            TxIdle:  if (write_en) tx_state_d = TxStart;
            TxStart: tx_state_d = TxData;
            TxData:  if (tx_idx_q == 3'd7) tx_state_d = TxStop;
            TxStop:  tx_state_d = write_en ? TxStart : TxIdle;
            default: tx_state_d = TxIdle;
         endcase
      end
   end

   // Stop with write_en high goes straight to a new start bit: no idle gap.
   always_comb begin
      tx_shift_d = tx_shift_q;
      tx_idx_d   = tx_idx_q;
      txd_d      = txd_q;
      busy_d     = busy_q;
      if (baud_tick) begin
         unique case (tx_state_q)
            TxIdle: begin
               if (write_en) begin
                  tx_shift_d = write_data;
                  txd_d      = 1'b0;
                  busy_d     = 1'b1;
               end
            end
            TxStart: begin
               txd_d    = tx_shift_q[0];
               tx_idx_d = 3'd0;
            end
            TxData: begin
               if (tx_idx_q == 3'd7) begin
                  txd_d = 1'b1;
               end else begin
                  tx_idx_d = tx_idx_q + 3'd1;
                  txd_d    = tx_shift_q[tx_idx_q + 3'd1];
               end
            end
            TxStop: begin
               if (write_en) begin
                  tx_shift_d = write_data;
                  txd_d      = 1'b0;
               end else begin
                  busy_d = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         tx_shift_q <= 8'h00;
         tx_idx_q   <= 3'd0;
         txd_q      <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         tx_shift_q <= tx_shift_d;
         tx_idx_q   <= tx_idx_d;
         txd_q      <= txd_d;
         busy_q     <= busy_d;
      end
   end

   assign uart_txd = txd_q;
   assign busy     = busy_q;

   // ---------------- receiver ----------------
   rx_state_e       rx_state_q, rx_state_d;
   logic            rx_meta_q, rx_sync_q;
   logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]      rx_idx_q, rx_idx_d;
   logic [7:0]      rx_shift_q, rx_shift_d;
   logic [7:0]      rx_byte_q, rx_byte_d;
   logic            rx_valid_q, rx_valid_d;

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_state_q <= RxIdle;
      end else begin
         rx_meta_q  <= data_serial;
         rx_sync_q  <= rx_meta_q;
         rx_state_q <= rx_state_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      unique case (rx_state_q)
         RxIdle:    if (!rx_sync_q) rx_state_d = RxStart;
         RxStart:   if (rx_cnt_q == CntHalf) rx_state_d = rx_sync_q ? RxIdle : RxData;
         RxData:    if (rx_cnt_q == CntMax && rx_idx_q == 3'd7) rx_state_d = RxStop;
         RxStop:    if (rx_cnt_q == CntMax) rx_state_d = RxCleanup;
         RxCleanup: rx_state_d = RxIdle;
         default:   rx_state_d = RxIdle;
      endcase
   end

   // Sampling is re-centred on mid-bit by the half-period wait in RxStart.
   always_comb begin
      rx_cnt_d   = rx_cnt_q;
      rx_idx_d   = rx_idx_q;
      rx_shift_d = rx_shift_q;
      rx_byte_d  = rx_byte_q;
      rx_valid_d = 1'b0;
      unique case (rx_state_q)
         RxIdle: begin
            rx_cnt_d = '0;
            rx_idx_d = 3'd0;
         end
         RxStart: rx_cnt_d = (rx_cnt_q == CntHalf) ? '0 : rx_cnt_q + CntW'(1);
         RxData: begin
            if (rx_cnt_q == CntMax) begin
               rx_cnt_d             = '0;
               rx_shift_d[rx_idx_q] = rx_sync_q;
               rx_idx_d             = rx_idx_q + 3'd1;
            end else begin
               rx_cnt_d = rx_cnt_q + CntW'(1);
            end
         end
         RxStop: begin
            if (rx_cnt_q == CntMax) begin
               rx_cnt_d = '0;
               if (rx_sync_q) begin
                  rx_byte_d  = rx_shift_q;
                  rx_valid_d = 1'b1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CntW'(1);
            end
         end
         RxCleanup: rx_cnt_d = '0;
         default:   rx_cnt_d = '0;
      endcase
   end

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         rx_cnt_q   <= '0;
         rx_idx_q   <= 3'd0;
         rx_shift_q <= 8'h00;
         rx_byte_q  <= 8'h00;
         rx_valid_q <= 1'b0;
      end else begin
         rx_cnt_q   <= rx_cnt_d;
         rx_idx_q   <= rx_idx_d;
         rx_shift_q <= rx_shift_d;
         rx_byte_q  <= rx_byte_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   assign out_RX_D    = rx_valid_q;
   assign out_RX_byte = rx_byte_q;

endmodule

// File: tb/tb_uart_txrx_core.sv
// Randomised loopback bench for uart_txrx_core against a frame-level line model.
// The model tracks bit-period position within a frame and a queue of bytes owed by RX.
module tb_uart_txrx_core;

   localparam int CPB   = 434;
   localparam int RxLat = 3 + CPB / 2 + 9 * CPB;  // start-bit edge to out_RX_D, ~9.5 bits + 3
   localparam int Slack = 4;

   logic       clk_50M = 1'b0;
   logic       rst_n = 1'b1;
   logic       write_en = 1'b0;
   logic [7:0] write_data = 8'h00;
   logic       uart_txd, busy, baud_tick;
   logic       data_serial;
   logic       out_RX_D;
   logic [7:0] out_RX_byte;
   logic       lb_sel = 1'b1;
   logic       line_drv = 1'b1;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   int         pos = -1;
   logic [7:0] cur = 8'h00;
   logic [7:0] last_byte = 8'h00;
   logic [7:0] exp_q[$];
   int         exp_t[$];

   assign data_serial = lb_sel ? uart_txd : line_drv;

   always #10 clk_50M = ~clk_50M;

   uart_txrx_core dut (
      .clk_50M     (clk_50M),
      .rst_n       (rst_n),
      .write_en    (write_en),
      .write_data  (write_data),
      .uart_txd    (uart_txd),
      .busy        (busy),
      .baud_tick   (baud_tick),
      .data_serial (data_serial),
      .out_RX_D    (out_RX_D),
      .out_RX_byte (out_RX_byte)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, want, cyc);
      end
   endtask

   function automatic logic exp_txd(input int p, input logic [7:0] b);
      if (p == -1 || p == 9) return 1'b1;
      if (p == 0) return 1'b0;
      return b[p-1];
   endfunction

   // Frame-level model: frames start on every CPB-th edge after reset release.
   always @(posedge clk_50M) begin
      #1;
      if (!rst_n) begin
         cyc = 0;
         pos = -1;
         last_byte = 8'h00;
         exp_q.delete();
         exp_t.delete();
      end else begin
         cyc++;
         if (cyc % CPB == 0) begin
            if (pos == -1 || pos == 9) begin
               if (write_en) begin
                  cur = write_data;
                  pos = 0;
                  exp_q.push_back(write_data);
                  exp_t.push_back(cyc + RxLat);
               end else begin
                  pos = -1;
               end
            end else begin
               pos++;
            end
         end
         if (cyc % CPB == CPB / 2) begin
            check_eq("txd", 32'(uart_txd), 32'(exp_txd(pos, cur)));
            check_eq("busy", 32'(busy), 32'(pos != -1));
            check_eq("rx_hold", 32'(out_RX_byte), 32'(last_byte));
         end
         if (cyc % CPB == CPB - 1)
            check_eq("tick_on", 32'(baud_tick), 32'd1);
         else if (cyc % CPB == CPB - 2 || cyc % CPB == 0)
            check_eq("tick_off", 32'(baud_tick), 32'd0);
         if (out_RX_D) begin
            if (exp_q.size() == 0) begin
               check_eq("rx_spurious", 32'(out_RX_D), 32'd0);
            end else begin
               check_eq("rx_byte", 32'(out_RX_byte), 32'(exp_q[0]));
               check_eq("rx_latency", 32'(cyc >= exp_t[0] - Slack && cyc <= exp_t[0] + Slack),
                        32'd1);
               last_byte = exp_q[0];
               void'(exp_q.pop_front());
               void'(exp_t.pop_front());
            end
         end else if (exp_q.size() > 0 && cyc > exp_t[0] + Slack) begin
            check_eq("rx_missing", 32'(out_RX_D), 32'd1);
            void'(exp_q.pop_front());
            void'(exp_t.pop_front());
         end
      end
   end

   task automatic clks(input int n);
      repeat (n) @(negedge clk_50M);
   endtask

   // Park stimulus changes well away from the baud boundary.
   task automatic align();
      do @(negedge clk_50M); while (cyc % CPB != 100);
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_txd"}, 32'(uart_txd), 32'd1);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_tick"}, 32'(baud_tick), 32'd0);
      check_eq({tag, "_rxd"}, 32'(out_RX_D), 32'd0);
      check_eq({tag, "_byte"}, 32'(out_RX_byte), 32'h00);
   endtask

   task automatic drive_bit(input logic v, input int n);
      line_drv = v;
      clks(n);
   endtask

   initial begin
      logic [7:0] b;
      #5 rst_n = 1'b0;
      #1 check_reset_values("rst");
      clks(3);
      rst_n = 1'b1;
      clks(1000);

      // 0x55 stream, then a mid-frame switch to 0x33 held across several frames.
      align();
      write_data = 8'h55;
      write_en   = 1'b1;
      clks(20 * CPB);
      write_data = 8'h33;
      clks(30 * CPB);
      write_en = 1'b0;
      clks(12 * CPB);

      // Random data changes and write_en toggles at bit-period granularity.
      align();
      write_en = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 3) == 0) write_data = 8'($urandom);
         if ($urandom_range(0, 7) == 0) write_en = ~write_en;
         clks(CPB);
      end
      write_en = 1'b0;
      clks(12 * CPB);

      // Reset in the middle of a 0xCF frame, then 0x45 frames after release.
      align();
      write_data = 8'hCF;
      write_en   = 1'b1;
      clks(15 * CPB);
      rst_n = 1'b0;
      #1 check_reset_values("midrst");
      write_data = 8'h45;
      clks(5);
      rst_n = 1'b1;
      align();
      clks(22 * CPB);
      write_en = 1'b0;
      clks(12 * CPB);

      // Short low glitch on the RX line.
      lb_sel = 1'b0;
      line_drv = 1'b1;
      clks(10);
      drive_bit(1'b0, 100);
      drive_bit(1'b1, 1000);
      check_eq("glitch_byte", 32'(out_RX_byte), 32'(last_byte));

      // Frame with the stop bit held low.
      b = 8'($urandom);
      drive_bit(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
      drive_bit(1'b0, 300);
      drive_bit(1'b1, 2000);
      check_eq("framing_byte", 32'(out_RX_byte), 32'(last_byte));
      check_eq("rx_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
